// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider.
// Contents: default operand width, iteration-counter width helper,
// and the FSM state encoding used by restoring_divider.
package div_pkg;

  localparam int DEF_WIDTH = 8;

  // Counter wide enough to hold 0..w.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_w(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_subtractor.sv
// Purely combinational N-bit subtractor built from a chain of full-adder
// cells: diff = a + ~b + 1.
// Ports:
//   a      in  N  minuend
//   b      in  N  subtrahend
//   diff   out N  a - b (modulo 2^N)
//   borrow out 1  1 when a < b (inverted carry-out of the chain)
module ripple_subtractor #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0]   w_carry;
  logic [N-1:0] w_b_n;

  assign w_b_n      = ~b;
  assign w_carry[0] = 1'b1;  // the +1 of two's-complement negation

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign diff[i]      = a[i] ^ w_b_n[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & w_b_n[i]) | (a[i] & w_carry[i]) |
                          (w_b_n[i] & w_carry[i]);
  end

  assign borrow = ~w_carry[N];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//
// Handshake: a request is accepted on a rising edge where start=1 and
// busy=0 (state IDLE). Once accepted, busy stays high until the cycle
// after the one-cycle done pulse; start is ignored (not queued) while
// busy=1. Results are valid when done=1 and stay held until the next
// accepted request reaches its DONE state.
//
// Ports:
//   clk, rst     clock, async active-high reset
//   start        request, sampled only when busy=0
//   dividend     numerator, captured on accept
//   divisor      denominator, captured on accept
//   busy         operation in progress (state != IDLE)
//   done         one-cycle result-valid pulse
//   quotient     result quotient (all ones on divide-by-zero)
//   remainder    result remainder (dividend on divide-by-zero)
//   div_by_zero  captured divisor was zero; held with the results
//   dbg_state    current FSM state for observation
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output state_t           dbg_state
);

  localparam int CW = cnt_w(WIDTH);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_r;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic [WIDTH:0]   w_rs;
  logic [WIDTH:0]   w_t;
  logic             w_borrow;
  logic [WIDTH:0]   w_r_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_last;
  logic             w_accept;
  logic             w_unused;

  // Shift in the next dividend bit, then trial-subtract the divisor.
  assign w_rs = {r_r[WIDTH-1:0], r_q[WIDTH-1]};

  ripple_subtractor #(.N(WIDTH + 1)) u_sub (
    .a      (w_rs),
    .b      ({1'b0, r_d}),
    .diff   (w_t),
    .borrow (w_borrow)
  );

  // Restore on borrow: keep the shifted value and record a 0 quotient bit.
  assign w_r_next = w_borrow ? w_rs : w_t;
  assign w_q_next = {r_q[WIDTH-2:0], ~w_borrow};
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_accept = (r_state == IDLE) && start;

  // Partial remainder stays below the divisor, so its top bit never feeds back.
  assign w_unused = r_r[WIDTH];

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (start) w_next_state = (divisor == '0) ? DONE : RUN;
      RUN:  if (w_last) w_next_state = DONE;
      DONE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d    <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_d   <= divisor;
        r_q   <= dividend;
        r_r   <= '0;
        r_cnt <= '0;
        if (divisor == '0) begin
          r_quot <= '1;
          r_rem  <= dividend;
          r_dbz  <= 1'b1;
        end
      end else if (r_state == RUN) begin
        r_r   <= w_r_next;
        r_q   <= w_q_next;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_quot <= w_q_next;
          r_rem  <= w_r_next[WIDTH-1:0];
          r_dbz  <= 1'b0;
        end
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
  assign dbg_state   = r_state;

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
Multi-cycle unsigned restoring divider, the inverse of the adder/multiplier accumulate path. It serves as the normalisation stage after the convolution accumulator, e.g. dividing a kernel sum by a weight total. It computes one quotient bit per clock by shift-and-subtract, using a ripple subtractor built from full-adder cells. A start/busy/done handshake decouples it from the accumulator.

Parameters:
WIDTH, 8, bit width of dividend, divisor, quotient and remainder (>=2)

Ports:
clk  input  1  single system clock, rising-edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only when busy=0
dividend  input  WIDTH  numerator; captured on accepted start
divisor  input  WIDTH  denominator; captured on accepted start
busy  output  1  high while an operation is in progress (state != IDLE)
done  output  1  one-cycle pulse when results become valid
quotient  output  WIDTH  result; held until next accepted start
remainder  output  WIDTH  result; held until next accepted start
div_by_zero  output  1  set with done when the captured divisor==0; held with results

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0. Applies mid-operation: the operation is abandoned and no done pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start=1:
  - latch D=divisor, Q=dividend, R=0 (WIDTH+1 bits), cnt=0.
  - If divisor==0: go to DONE directly.
  - Otherwise: go to RUN.
- RUN, each edge performs one iteration:
  - Rs = {R[WIDTH-1:0], Q[WIDTH-1]}; T = Rs - {1'b0, D} via the subtractor.
  - No borrow: R=T, Q={Q[WIDTH-2:0],1}.
  - Borrow: R=Rs, Q={Q[WIDTH-2:0],0}.
  - cnt++; on the WIDTH-th iteration edge go to DONE.
- DONE (exactly one cycle): done=1, busy=1; next edge goes to IDLE and done=0.
- Output registers are written on the edge entering DONE:
  - Normal: quotient=Q, remainder=R[WIDTH-1:0], div_by_zero=0.
  - Divide-by-zero: quotient=all ones, remainder=dividend, div_by_zero=1.
- Latency:
  - Normal: start sampled at edge 0; done high after edge WIDTH, for one cycle; busy high from edge 0 through edge WIDTH+1.
  - Divide-by-zero: done high after edge 1.
- start while busy=1 (RUN or DONE) is ignored; it is not queued. The earliest new accept is the first edge at which busy=0.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- Results and div_by_zero remain stable in IDLE until the next accepted start overwrites them at DONE entry. They are not cleared on accept.
- Arithmetic is unsigned only; the remainder is always < divisor when divisor != 0. No overflow is possible.

Decomposition:
- Shared package div_pkg:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - default WIDTH
  - counter width CNT_W = clog2(WIDTH+1)
- One sub-module, ripple_subtractor (parameter N=WIDTH+1): computes A + ~B + 1 as a chain of full-adder cells and outputs diff[N-1:0] and borrow (= ~carry_out). It is purely combinational; the divider instantiates one.

Test Plan:
- dividend=100, divisor=7, start 1 cycle -> busy rises; done pulses exactly 8 cycles after start sampled; quotient=14, remainder=2, div_by_zero=0.
- dividend=255, divisor=1 -> quotient=255, remainder=0; dividend=5, divisor=9 -> quotient=0, remainder=5; each with correct done timing.
- dividend=42, divisor=0 -> done 1 cycle after start; quotient=8'hFF, remainder=42, div_by_zero=1; a following 42/6 -> quotient=7, div_by_zero=0.
- Start 20/3, then pulse start with 200/10 at cycle 3 while busy -> second request ignored; quotient=6, remainder=2; only one done pulse.
- Assert rst asynchronously mid-RUN (cycle 4 of 250/5) -> all outputs 0 immediately, no done pulse; next start 250/5 -> quotient=50, remainder=0.
- Back-to-back: start asserted on the first cycle busy=0 after done -> accepted; previous results held until the new DONE entry.
